// File: rtl/morse_player_if.sv
// Start/pattern request and serial status bundle for morse_player; no backpressure beyond busy.
interface morse_player_if #(
   parameter int PAT_W = 12,
   parameter int LEN_W = $clog2(PAT_W + 1)
);
   logic             start;
   logic [PAT_W-1:0] pat;
   logic [LEN_W-1:0] len;
   logic             abort;
   logic             out;
   logic             busy;
   logic             done;

   modport master (output start, pat, len, abort, input out, busy, done);
   modport slave  (input start, pat, len, abort, output out, busy, done);
endinterface

// File: rtl/morse_player.sv
// Serialises a pattern LSB-first, DIV cycles per symbol, first symbol 1 cycle after start; MORSE_REPEAT_EN adds looping with a GAP-symbol pause.
// No backpressure: start is ignored while busy, abort drops the play with no done pulse.
module morse_player #(
   parameter int PAT_W = 12,
   parameter int DIV   = 25000000,
   parameter int GAP   = 3,
   parameter int LEN_W = $clog2(PAT_W + 1)
) (
   input logic           clk,
   input logic           reset,
   morse_player_if.slave bus
);
   localparam logic [27:0]      DIV_M1  = 28'(DIV - 1);
   localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(PAT_W);

   if (DIV < 1 || DIV > 268435455 || GAP < 0) begin : g_bad_param
      $error("morse_player: DIV must be 1..2^28-1 and GAP non-negative");
   end

`ifdef MORSE_REPEAT_EN
   typedef enum logic [1:0] {S_IDLE, S_PLAY, S_GAP} state_t;
   localparam int GAP_W = (GAP < 2) ? 1 : $clog2(GAP + 1);
`else
   typedef enum logic [1:0] {S_IDLE, S_PLAY} state_t;
`endif

   state_t           state_q, state_d;
   logic [PAT_W-1:0] shreg_q, shreg_d;
   logic [LEN_W-1:0] cnt_q,   cnt_d;
   logic [LEN_W-1:0] len_q,   len_d;
   logic [27:0]      div_q,   div_d;
   logic             done_q,  done_d;
`ifdef MORSE_REPEAT_EN
   logic [PAT_W-1:0] pat_copy_q, pat_copy_d;
   logic [GAP_W-1:0] gap_cnt_q,  gap_cnt_d;
   logic [GAP_W-1:0] gap_inc;
`endif

   logic             tick;
   logic [LEN_W-1:0] cnt_inc;
   logic [LEN_W-1:0] eff_len;

   assign tick    = (div_q == '0);
   assign cnt_inc = cnt_q + LEN_W'(1);
   assign eff_len = (bus.len > MAX_LEN) ? MAX_LEN : bus.len;
`ifdef MORSE_REPEAT_EN
   assign gap_inc = gap_cnt_q + GAP_W'(1);
`endif

   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      cnt_d   = cnt_q;
      len_d   = len_q;
      div_d   = div_q;
      done_d  = 1'b0;
`ifdef MORSE_REPEAT_EN
      pat_copy_d = pat_copy_q;
      gap_cnt_d  = gap_cnt_q;
`endif
      if (bus.abort) begin
         state_d = S_IDLE;
         shreg_d = '0;
         cnt_d   = '0;
         div_d   = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (bus.start) begin
                  if (bus.len == '0) begin
                     done_d = 1'b1;
                  end else begin
                     state_d = S_PLAY;
                     shreg_d = bus.pat;
                     cnt_d   = '0;
                     len_d   = eff_len;
                     div_d   = DIV_M1;
`ifdef MORSE_REPEAT_EN
                     pat_copy_d = bus.pat;
`endif
                  end
               end
            end
            S_PLAY: begin
               if (!tick) begin
                  div_d = div_q - 28'd1;
               end else begin
                  div_d   = DIV_M1;
                  shreg_d = shreg_q >> 1;
                  cnt_d   = cnt_inc;
                  if (cnt_inc == len_q) begin
                     cnt_d = '0;
`ifdef MORSE_REPEAT_EN
                     // Start still held at the last tick keeps the loop going.
                     if (bus.start) begin
                        gap_cnt_d = '0;
                        if (GAP == 0) begin
                           shreg_d = pat_copy_q;
                        end else begin
                           state_d = S_GAP;
                        end
                     end else begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                     end
`else
                     state_d = S_IDLE;
                     done_d  = 1'b1;
`endif
                  end
               end
            end
`ifdef MORSE_REPEAT_EN
            S_GAP: begin
               if (!tick) begin
                  div_d = div_q - 28'd1;
               end else begin
                  div_d = DIV_M1;
                  if (gap_inc == GAP_W'(GAP)) begin
                     gap_cnt_d = '0;
                     if (bus.start) begin
                        state_d = S_PLAY;
                        shreg_d = pat_copy_q;
                        cnt_d   = '0;
                     end else begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                     end
                  end else begin
                     gap_cnt_d = gap_inc;
                  end
               end
            end
`endif
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= S_IDLE;
         shreg_q <= '0;
         cnt_q   <= '0;
         len_q   <= '0;
         div_q   <= '0;
         done_q  <= 1'b0;
`ifdef MORSE_REPEAT_EN
         pat_copy_q <= '0;
         gap_cnt_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         cnt_q   <= cnt_d;
         len_q   <= len_d;
         div_q   <= div_d;
         done_q  <= done_d;
`ifdef MORSE_REPEAT_EN
         pat_copy_q <= pat_copy_d;
         gap_cnt_q  <= gap_cnt_d;
`endif
      end
   end

   assign bus.out  = (state_q == S_PLAY) & shreg_q[0];
   assign bus.busy = (state_q != S_IDLE);
   assign bus.done = done_q;
endmodule
